// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory initiator: FSM state encoding and
// memory geometry constants.
package mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 9;
    localparam int MEM_DEPTH  = 512;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_CAP   = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/mem_data_reg.sv
// Memory data register: loads from the datapath bus or from RAM read data,
// with synchronous active-high Clear.
module mem_data_reg #(
    parameter int DATA_W = 32
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              i_loadBus,
    input  logic              i_loadMem,
    input  logic [DATA_W-1:0] i_bus,
    input  logic [DATA_W-1:0] i_mem,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_mdr;

    // Capture from RAM takes priority; the controller never asserts both loads together.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_mdr <= '0;
        end else if (i_loadMem) begin
            r_mdr <= i_mem;
        end else if (i_loadBus) begin
            r_mdr <= i_bus;
        end
    end

    assign o_q = r_mdr;

endmodule

// File: rtl/mem_access_ctrl.sv
// Main-memory initiator: MAR/MDR, request FSM and single-cycle RAM strobes.
// Optional MEM_ADDR_CHECK_EN flags MAR values beyond the 512-word RAM with Err.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] BusMuxOut,
    output logic [DATA_W-1:0] MDR_q,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic              Mem_Read,
    output logic              Mem_Write,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Datain,
    input  logic [DATA_W-1:0] Mem_Dataout
);

    state_t            r_state;
    state_t            w_nextState;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] w_marNext;
    logic              w_idle;
    logic              w_request;
    logic              w_addrErr;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_request = w_idle && (Read || Write);
    assign w_marNext = (w_idle && MARin) ? BusMuxOut : r_mar;

    // The range check looks at the MAR value being loaded this edge, so a
    // same-edge MARin and request behave as if the load came first.
`ifdef MEM_ADDR_CHECK_EN
    logic r_err;

    assign w_addrErr = |w_marNext[DATA_W-1:ADDR_W];

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_request && w_addrErr;
        end
    end

    assign Err = r_err;
`else
    logic w_unusedMarHigh;

    assign w_unusedMarHigh = |r_mar[DATA_W-1:ADDR_W];
    assign w_addrErr       = 1'b0;
    assign Err             = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= ST_IDLE;
            r_mar   <= '0;
        end else begin
            r_state <= w_nextState;
            r_mar   <= w_marNext;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_request) begin
                    if (w_addrErr) begin
                        w_nextState = ST_DONE;
                    end else if (Write) begin
                        w_nextState = ST_WR_ISSUE;
                    end else begin
                        w_nextState = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: w_nextState = ST_RD_CAP;
            ST_RD_CAP:   w_nextState = ST_DONE;
            ST_WR_ISSUE: w_nextState = ST_DONE;
            ST_DONE:     w_nextState = ST_IDLE;
            default:     w_nextState = ST_IDLE;
        endcase
    end

    assign Busy        = !w_idle;
    assign Done        = (r_state == ST_DONE);
    assign Mem_Read    = (r_state == ST_RD_ISSUE);
    assign Mem_Write   = (r_state == ST_WR_ISSUE);
    assign Mem_Address = r_mar[ADDR_W-1:0];
    assign Mem_Datain  = MDR_q;

    mem_data_reg #(
        .DATA_W (DATA_W)
    ) u_mdr (
        .Clock     (Clock),
        .Clear     (Clear),
        .i_loadBus (w_idle && MDRin),
        .i_loadMem (r_state == ST_RD_CAP),
        .i_bus     (BusMuxOut),
        .i_mem     (Mem_Dataout),
        .o_q       (MDR_q)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small registered-read RAM model;
// expectations follow the MEM_ADDR_CHECK_EN setting of the build.
module tb_mem_access_ctrl;

    logic        clock;
    logic        clear;
    logic        marIn;
    logic        mdrIn;
    logic        readReq;
    logic        writeReq;
    logic [31:0] busMuxOut;
    logic [31:0] mdrQ;
    logic        busy;
    logic        done;
    logic        err;
    logic        memRead;
    logic        memWrite;
    logic [8:0]  memAddress;
    logic [31:0] memDatain;
    logic [31:0] memDataout;

    logic [31:0] ram [0:511];
    int          checks;
    int          failures;

    mem_access_ctrl dut (
        .Clock       (clock),
        .Clear       (clear),
        .MARin       (marIn),
        .MDRin       (mdrIn),
        .Read        (readReq),
        .Write       (writeReq),
        .BusMuxOut   (busMuxOut),
        .MDR_q       (mdrQ),
        .Busy        (busy),
        .Done        (done),
        .Err         (err),
        .Mem_Read    (memRead),
        .Mem_Write   (memWrite),
        .Mem_Address (memAddress),
        .Mem_Datain  (memDatain),
        .Mem_Dataout (memDataout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM with registered read data, one edge after the read strobe.
    always @(posedge clock) begin
        if (memWrite) ram[memAddress] <= memDatain;
        if (memRead) memDataout <= ram[memAddress];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic mi, input logic di,
                                 input logic rd, input logic wr, input logic [31:0] bus);
        clear     = c;
        marIn     = mi;
        mdrIn     = di;
        readReq   = rd;
        writeReq  = wr;
        busMuxOut = bus;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 512; i++) ram[i] = 32'h1000_0000 + i;
        ram[0] = 32'hA5A5_0000;
        memDataout = '0;

        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        tick();
        tick();
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        checkOutput("rst_mdr", mdrQ, 32'h0);
        checkOutput("rst_addr", {23'b0, memAddress}, 32'h0);
        checkOutput("rst_strobes", {30'b0, memRead, memWrite}, 32'd0);

        // Test 1: write DEADBEEF to 0x1A5, then read it back.
        applyStimulus(0, 1, 0, 0, 0, 32'h0000_01A5);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 32'hDEAD_BEEF);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("t1_wr_strobe", {30'b0, memRead, memWrite}, 32'd1);
        checkOutput("t1_wr_addr", {23'b0, memAddress}, 32'h1A5);
        checkOutput("t1_wr_data", memDatain, 32'hDEAD_BEEF);
        checkOutput("t1_wr_busy", {31'b0, busy}, 32'd1);
        checkOutput("t1_wr_nodone", {31'b0, done}, 32'd0);
        tick();
        checkOutput("t1_wr_done", {31'b0, done}, 32'd1);
        checkOutput("t1_wr_strobe_off", {30'b0, memRead, memWrite}, 32'd0);
        tick();
        checkOutput("t1_wr_done_off", {31'b0, done}, 32'd0);
        checkOutput("t1_wr_idle", {31'b0, busy}, 32'd0);
        checkOutput("t1_ram_word", ram[9'h1A5], 32'hDEAD_BEEF);
        applyStimulus(0, 0, 1, 0, 0, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        checkOutput("t1_mdr_cleared", mdrQ, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("t1_rd_strobe", {30'b0, memRead, memWrite}, 32'd2);
        tick();
        checkOutput("t1_rd_cap_strobe", {30'b0, memRead, memWrite}, 32'd0);
        checkOutput("t1_rd_cap_nodone", {31'b0, done}, 32'd0);
        tick();
        checkOutput("t1_rd_done", {31'b0, done}, 32'd1);
        checkOutput("t1_rd_mdr", mdrQ, 32'hDEAD_BEEF);
        tick();
        checkOutput("t1_rd_done_off", {31'b0, done}, 32'd0);

        // Test 2: simultaneous Read and Write, write wins.
        applyStimulus(0, 0, 1, 0, 0, 32'h1234_5678);
        tick();
        applyStimulus(0, 0, 0, 1, 1, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("t2_only_write", {30'b0, memRead, memWrite}, 32'd1);
        tick();
        checkOutput("t2_done", {31'b0, done}, 32'd1);
        checkOutput("t2_no_read", {31'b0, memRead}, 32'd0);
        tick();
        checkOutput("t2_ram_word", ram[9'h1A5], 32'h1234_5678);

        // Test 4: requests and loads while busy are ignored.
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 1, 1, 0, 1, 32'h0);
        tick();
        checkOutput("t4_mar_kept", {23'b0, memAddress}, 32'h1A5);
        checkOutput("t4_no_write", {31'b0, memWrite}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        tick();
        checkOutput("t4_done", {31'b0, done}, 32'd1);
        checkOutput("t4_mdr_read", mdrQ, 32'h1234_5678);
        tick();
        checkOutput("t4_mar_after", {23'b0, memAddress}, 32'h1A5);
        checkOutput("t4_not_queued", {31'b0, busy}, 32'd0);
        tick();
        checkOutput("t4_still_idle", {30'b0, memRead, memWrite}, 32'd0);

        // Test 3: Clear during RD_CAP aborts the read.
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("t3_idle", {31'b0, busy}, 32'd0);
        checkOutput("t3_mdr", mdrQ, 32'h0);
        checkOutput("t3_mar", {23'b0, memAddress}, 32'h0);
        checkOutput("t3_nodone0", {31'b0, done}, 32'd0);
        tick();
        checkOutput("t3_nodone1", {31'b0, done}, 32'd0);
        tick();
        checkOutput("t3_nodone2", {31'b0, done}, 32'd0);

        // Test 5: MAR beyond the RAM range.
        applyStimulus(0, 1, 0, 0, 0, 32'h0000_0200);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 32'hCAFE_F00D);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
`ifdef MEM_ADDR_CHECK_EN
        checkOutput("t5_err_done", {30'b0, done, err}, 32'd3);
        checkOutput("t5_no_strobe", {30'b0, memRead, memWrite}, 32'd0);
        tick();
        checkOutput("t5_err_off", {30'b0, done, err}, 32'd0);
        checkOutput("t5_mdr_kept", mdrQ, 32'hCAFE_F00D);
`else
        checkOutput("t5_wrap_strobe", {30'b0, memRead, memWrite}, 32'd2);
        checkOutput("t5_wrap_addr", {23'b0, memAddress}, 32'h0);
        checkOutput("t5_no_err", {31'b0, err}, 32'd0);
        tick();
        tick();
        checkOutput("t5_done", {30'b0, done, err}, 32'd2);
        checkOutput("t5_mdr_word0", mdrQ, 32'hA5A5_0000);
        tick();
`endif

        // Test 6: Read in the DONE cycle is dropped, the next one is accepted.
        applyStimulus(0, 1, 0, 0, 0, 32'h0000_01A5);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        tick();
        tick();
        checkOutput("t6_done", {31'b0, done}, 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 32'h0);
        tick();
        checkOutput("t6_ignored_busy", {31'b0, busy}, 32'd0);
        checkOutput("t6_ignored_strobe", {31'b0, memRead}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("t6_accepted", {31'b0, memRead}, 32'd1);
        checkOutput("t6_busy", {31'b0, busy}, 32'd1);
        tick();
        tick();
        checkOutput("t6_done2", {31'b0, done}, 32'd1);
        checkOutput("t6_mdr", mdrQ, 32'h1234_5678);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
